// File: rtl/gshare_predictor_pkg.sv
// ---------------------------------------------------------------------------
// gshare_predictor_pkg
// Shared constants and helpers for the gshare branch predictor slice.
//   ADDR_W_DEF      : default PC width
//   IDX_W_DEF       : default pattern-history-table index width
//   CTR_W_DEF       : default saturating counter width
//   HIST_W_DEF      : default global history length
//   CTR_RST_DEF     : reset value of a default-width counter (weakly taken)
//   ctrResetValue() : weakly-taken reset value for any counter width
// ---------------------------------------------------------------------------
package gshare_predictor_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int IDX_W_DEF  = 7;
  localparam int CTR_W_DEF  = 2;
  localparam int HIST_W_DEF = 6;

  typedef logic [31:0] perfCount_t;

  // Weakly taken: only the MSB of the counter is set.
  function automatic int unsigned ctrResetValue(input int unsigned ctrW);
    return 32'd1 << (ctrW - 1);
  endfunction

  localparam logic [CTR_W_DEF-1:0] CTR_RST_DEF = CTR_W_DEF'(ctrResetValue(CTR_W_DEF));

endpackage

// File: rtl/gshare_predictor_if.sv
// ---------------------------------------------------------------------------
// gshare_predictor_if
// Fetch-side lookup and ROB-side commit signals of the gshare predictor.
//   master : fetch unit / ROB side (drives PCs, valid, commit information)
//   slave  : predictor side (returns prediction, history snapshot, perf counts)
// ---------------------------------------------------------------------------
interface gshare_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int HIST_W = 6
);

  logic [ADDR_W-1:0] if_to_pr_PC;
  logic              if_to_pr_valid;
  logic              pr_to_if_prediction;
  logic [HIST_W-1:0] pr_to_if_hist;
  logic              rob_to_pr_br_commit;
  logic [ADDR_W-1:0] rob_to_pr_PC;
  logic [HIST_W-1:0] rob_to_pr_hist;
  logic              rob_to_pr_br_taken;
  logic              rob_to_pr_mispredict;
  logic [31:0]       pr_perf_branches;
  logic [31:0]       pr_perf_mispredicts;

  modport master (
    output if_to_pr_PC, if_to_pr_valid,
    output rob_to_pr_br_commit, rob_to_pr_PC, rob_to_pr_hist,
    output rob_to_pr_br_taken, rob_to_pr_mispredict,
    input  pr_to_if_prediction, pr_to_if_hist,
    input  pr_perf_branches, pr_perf_mispredicts
  );

  modport slave (
    input  if_to_pr_PC, if_to_pr_valid,
    input  rob_to_pr_br_commit, rob_to_pr_PC, rob_to_pr_hist,
    input  rob_to_pr_br_taken, rob_to_pr_mispredict,
    output pr_to_if_prediction, pr_to_if_hist,
    output pr_perf_branches, pr_perf_mispredicts
  );

endinterface

// File: rtl/gshare_predictor_sat_counter_update.sv
// ---------------------------------------------------------------------------
// sat_counter_update
// Combinational next value of a CTR_W-bit saturating up/down counter.
//   i_ctr   : current counter value
//   i_taken : 1 = count up, 0 = count down
//   o_ctr   : next value, clamped at all-ones and zero (never wraps)
// ---------------------------------------------------------------------------
module sat_counter_update #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_ctr
);

  // Move one step toward the resolved direction unless already at that end.
  always_comb begin
    o_ctr = i_ctr;
    if (i_taken && (i_ctr != {CTR_W{1'b1}})) begin
      o_ctr = i_ctr + CTR_W'(1);
    end else if (!i_taken && (i_ctr != {CTR_W{1'b0}})) begin
      o_ctr = i_ctr - CTR_W'(1);
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// ---------------------------------------------------------------------------
// gshare_predictor
// Global-history (gshare) branch direction predictor with a register-array
// pattern history table of 2^IDX_W saturating counters.
//   clk_in / rst_in : clock, asynchronous active-high reset
//   rdy_in          : global enable, all state holds while low
//   bus (slave)     : fetch lookup (PC, valid -> prediction, history snapshot),
//                     ROB commit (PC, history snapshot, direction, mispredict),
//                     committed-branch and mispredict performance counters
// ---------------------------------------------------------------------------
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int CTR_W  = CTR_W_DEF,
  parameter int HIST_W = HIST_W_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  gshare_predictor_if.slave bus
);

  localparam int PHT_N = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctrResetValue(CTR_W));

  logic [CTR_W-1:0]  r_pht [PHT_N];
  logic [HIST_W-1:0] r_specGhr;
  logic [HIST_W-1:0] r_archGhr;
  perfCount_t        r_perfBranches;
  perfCount_t        r_perfMispredicts;

  logic [ADDR_W-1:0] w_fetchPc;
  logic [ADDR_W-1:0] w_commitPc;
  logic [IDX_W-1:0]  w_lookupIdx;
  logic [IDX_W-1:0]  w_updateIdx;
  logic              w_prediction;
  logic [CTR_W-1:0]  w_ctrNext;
  logic [HIST_W-1:0] w_specShift;
  logic [HIST_W-1:0] w_archNext;
  logic              w_update;
  logic              w_restore;

  assign w_fetchPc  = bus.if_to_pr_PC;
  assign w_commitPc = bus.rob_to_pr_PC;

  // Word-aligned PC bits [IDX_W+1:2] hashed with the zero-extended history.
  assign w_lookupIdx = IDX_W'(w_fetchPc >> 2) ^ IDX_W'(r_specGhr);
  assign w_updateIdx = IDX_W'(w_commitPc >> 2) ^ IDX_W'(bus.rob_to_pr_hist);

  // Read straight from the array: a same-cycle commit to this entry is not bypassed.
  assign w_prediction = r_pht[w_lookupIdx][CTR_W-1];

  // Shift-left-and-insert written as a truncating concat so HIST_W=1 also works.
  assign w_specShift = HIST_W'({r_specGhr, w_prediction});
  assign w_archNext  = HIST_W'({r_archGhr, bus.rob_to_pr_br_taken});

  assign w_update  = rdy_in && bus.rob_to_pr_br_commit;
  assign w_restore = w_update && bus.rob_to_pr_mispredict;

  sat_counter_update #(
    .CTR_W (CTR_W)
  ) u_satCounterUpdate (
    .i_ctr   (r_pht[w_updateIdx]),
    .i_taken (bus.rob_to_pr_br_taken),
    .o_ctr   (w_ctrNext)
  );

  // Pattern history table: every entry reset to weakly taken, one entry
  // trained per committed branch.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < PHT_N; i++) begin
        r_pht[i] <= CTR_RST;
      end
    end else if (w_update) begin
      r_pht[w_updateIdx] <= w_ctrNext;
    end
  end

  // Global histories: the speculative copy advances with each fetched branch
  // and is rebuilt from the architectural copy on a mispredict, which wins
  // over a fetch in the same cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_specGhr <= '0;
      r_archGhr <= '0;
    end else if (rdy_in) begin
      if (w_restore) begin
        r_specGhr <= w_archNext;
      end else if (bus.if_to_pr_valid) begin
        r_specGhr <= w_specShift;
      end
      if (w_update) begin
        r_archGhr <= w_archNext;
      end
    end
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_perfBranches    <= '0;
      r_perfMispredicts <= '0;
    end else if (w_update) begin
      if (r_perfBranches != '1) begin
        r_perfBranches <= r_perfBranches + 32'd1;
      end
      if (bus.rob_to_pr_mispredict && (r_perfMispredicts != '1)) begin
        r_perfMispredicts <= r_perfMispredicts + 32'd1;
      end
    end
  end

  assign bus.pr_to_if_prediction = w_prediction;
  assign bus.pr_to_if_hist       = r_specGhr;
  assign bus.pr_perf_branches    = r_perfBranches;
  assign bus.pr_perf_mispredicts = r_perfMispredicts;

endmodule

// File: tb/tb_gshare_predictor.sv
// ---------------------------------------------------------------------------
// tb_gshare_predictor
// Drives a default-parameter predictor (A) and a CTR_W=3 / HIST_W=4 predictor
// (B) with the same directed stimulus. An arithmetic reference model is
// compared against both on every falling edge, and directed steps add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_gshare_predictor;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        rdy    = 1'b1;
  logic        valid  = 1'b0;
  logic        commit = 1'b0;
  logic        taken  = 1'b0;
  logic        misp   = 1'b0;
  logic [31:0] pcF    = '0;
  logic [31:0] pcR    = '0;
  logic [5:0]  histR  = '0;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: counters as plain integers, histories as integers
  // kept modulo 2^HIST_W.
  int          phtA [128];
  int          phtB [128];
  int          specA, archA, specB, archB;
  int unsigned mBr, mMp;

  gshare_predictor_if #(.ADDR_W(32), .HIST_W(6)) ifA ();
  gshare_predictor_if #(.ADDR_W(32), .HIST_W(4)) ifB ();

  assign ifA.if_to_pr_PC          = pcF;
  assign ifA.if_to_pr_valid       = valid;
  assign ifA.rob_to_pr_br_commit  = commit;
  assign ifA.rob_to_pr_PC         = pcR;
  assign ifA.rob_to_pr_hist       = histR;
  assign ifA.rob_to_pr_br_taken   = taken;
  assign ifA.rob_to_pr_mispredict = misp;

  assign ifB.if_to_pr_PC          = pcF;
  assign ifB.if_to_pr_valid       = valid;
  assign ifB.rob_to_pr_br_commit  = commit;
  assign ifB.rob_to_pr_PC         = pcR;
  assign ifB.rob_to_pr_hist       = histR[3:0];
  assign ifB.rob_to_pr_br_taken   = taken;
  assign ifB.rob_to_pr_mispredict = misp;

  gshare_predictor #(
    .ADDR_W (32), .IDX_W (7), .CTR_W (2), .HIST_W (6)
  ) dutA (
    .clk_in (clk), .rst_in (rst), .rdy_in (rdy), .bus (ifA.slave)
  );

  gshare_predictor #(
    .ADDR_W (32), .IDX_W (7), .CTR_W (3), .HIST_W (4)
  ) dutB (
    .clk_in (clk), .rst_in (rst), .rdy_in (rdy), .bus (ifB.slave)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Change inputs just after a rising edge so they are stable for the next one.
  task automatic applyStimulus(input logic v, input logic [31:0] fpc, input logic c,
                               input logic [31:0] rpc, input logic [5:0] h,
                               input logic t, input logic m);
    @(posedge clk);
    #1;
    valid  = v;
    pcF    = fpc;
    commit = c;
    pcR    = rpc;
    histR  = h;
    taken  = t;
    misp   = m;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // n commits at PC 0x100 / history 0 while looking up PC 0x100, then one idle cycle.
  task automatic commitBurst(input int n, input logic t);
    repeat (n) applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 6'd0, t, 1'b0);
    applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    settle();
  endtask

  // Reference model and per-cycle comparison: outputs are checked against the
  // model's current state, then the model takes the step the next rising edge
  // will take.
  initial begin
    int  idxA, idxB, uA, uB;
    bit  predA, predB;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 128; i++) begin
          phtA[i] = 2;
          phtB[i] = 4;
        end
        specA = 0; archA = 0; specB = 0; archB = 0;
        mBr = 0; mMp = 0;
      end else begin
        idxA  = int'((pcF >> 2) & 32'h7F) ^ specA;
        idxB  = int'((pcF >> 2) & 32'h7F) ^ specB;
        predA = (phtA[idxA] >= 2);
        predB = (phtB[idxB] >= 4);
        checkOutput("model predA", 32'(ifA.pr_to_if_prediction), 32'(predA));
        checkOutput("model histA", 32'(ifA.pr_to_if_hist), specA);
        checkOutput("model brA",   ifA.pr_perf_branches, mBr);
        checkOutput("model mpA",   ifA.pr_perf_mispredicts, mMp);
        checkOutput("model predB", 32'(ifB.pr_to_if_prediction), 32'(predB));
        checkOutput("model histB", 32'(ifB.pr_to_if_hist), specB);
        checkOutput("model brB",   ifB.pr_perf_branches, mBr);
        checkOutput("model mpB",   ifB.pr_perf_mispredicts, mMp);
        if (rdy) begin
          if (commit) begin
            uA = int'((pcR >> 2) & 32'h7F) ^ (int'(histR) % 64);
            uB = int'((pcR >> 2) & 32'h7F) ^ (int'(histR) % 16);
            if (taken) begin
              if (phtA[uA] < 3) phtA[uA] = phtA[uA] + 1;
              if (phtB[uB] < 7) phtB[uB] = phtB[uB] + 1;
            end else begin
              if (phtA[uA] > 0) phtA[uA] = phtA[uA] - 1;
              if (phtB[uB] > 0) phtB[uB] = phtB[uB] - 1;
            end
            if (misp) begin
              specA = (archA * 2 + int'(taken)) % 64;
              specB = (archB * 2 + int'(taken)) % 16;
              if (mMp != 32'hFFFF_FFFF) mMp++;
            end else if (valid) begin
              specA = (specA * 2 + int'(predA)) % 64;
              specB = (specB * 2 + int'(predB)) % 16;
            end
            archA = (archA * 2 + int'(taken)) % 64;
            archB = (archB * 2 + int'(taken)) % 16;
            if (mBr != 32'hFFFF_FFFF) mBr++;
          end else if (valid) begin
            specA = (specA * 2 + int'(predA)) % 64;
            specB = (specB * 2 + int'(predB)) % 16;
          end
        end
      end
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    checkOutput("reset predA", 32'(ifA.pr_to_if_prediction), 32'd1);
    checkOutput("reset histA", 32'(ifA.pr_to_if_hist), 32'd0);
    checkOutput("reset brA",   ifA.pr_perf_branches, 32'd0);
    checkOutput("reset mpA",   ifA.pr_perf_mispredicts, 32'd0);
    checkOutput("reset predB", 32'(ifB.pr_to_if_prediction), 32'd1);
    checkOutput("reset histB", 32'(ifB.pr_to_if_hist), 32'd0);

    // Two not-taken commits at PC 0x100 drive entry 0x40 to 00.
    applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    settle();
    checkOutput("ntTwice predA", 32'(ifA.pr_to_if_prediction), 32'd0);
    applyStimulus(1'b0, 32'h100, 1'b1, 32'h100, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h100, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    settle();
    checkOutput("ntFloor predA", 32'(ifA.pr_to_if_prediction), 32'd0);
    checkOutput("ntFloor brA",   ifA.pr_perf_branches, 32'd3);

    // Fetches predicting 1 (idx 0), 0 (idx 0x41^1=0x40), 1 (idx 0^2) -> 000101.
    applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h104, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h200, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    settle();
    checkOutput("shift histA", 32'(ifA.pr_to_if_hist), 32'h05);
    checkOutput("shift histB", 32'(ifB.pr_to_if_hist), 32'h5);

    // Taken mispredict with arch history 0 restores speculative history to 1.
    applyStimulus(1'b0, 32'h200, 1'b1, 32'h80, 6'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h200, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    settle();
    checkOutput("restore histA", 32'(ifA.pr_to_if_hist), 32'h01);
    checkOutput("restore histB", 32'(ifB.pr_to_if_hist), 32'h1);
    checkOutput("restore mpA",   ifA.pr_perf_mispredicts, 32'd1);

    // Fetch and mispredict together: arch 1 + not taken gives 2, not the shift value 3.
    applyStimulus(1'b1, 32'h200, 1'b1, 32'h80, 6'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h200, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    settle();
    checkOutput("override histA", 32'(ifA.pr_to_if_hist), 32'h02);

    // Entry 0x10 set to 01, then trained taken while being looked up.
    applyStimulus(1'b0, 32'h48, 1'b1, 32'h40, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h48, 1'b1, 32'h40, 6'd0, 1'b1, 1'b0);
    settle();
    checkOutput("noBypass predA", 32'(ifA.pr_to_if_prediction), 32'd0);
    checkOutput("noBypass predB", 32'(ifB.pr_to_if_prediction), 32'd0);
    applyStimulus(1'b0, 32'h48, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    settle();
    checkOutput("nextCycle predA", 32'(ifA.pr_to_if_prediction), 32'd1);
    checkOutput("nextCycle predB", 32'(ifB.pr_to_if_prediction), 32'd1);

    // Five frozen cycles with commit and fetch active.
    applyStimulus(1'b1, 32'h48, 1'b1, 32'h40, 6'd0, 1'b1, 1'b1);
    rdy = 1'b0;
    repeat (5) begin
      settle();
      checkOutput("frozen histA", 32'(ifA.pr_to_if_hist), 32'h02);
      checkOutput("frozen brA",   ifA.pr_perf_branches, 32'd7);
      checkOutput("frozen mpA",   ifA.pr_perf_mispredicts, 32'd2);
    end
    applyStimulus(1'b0, 32'h48, 1'b0, 32'h0, 6'd0, 1'b0, 1'b0);
    rdy = 1'b1;
    settle();
    checkOutput("thawed histA", 32'(ifA.pr_to_if_hist), 32'h02);
    checkOutput("thawed brA",   ifA.pr_perf_branches, 32'd7);

    // Reset lands in the middle of a cycle carrying a commit.
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 6'd0, 1'b1, 1'b1);
    rst = 1'b1;
    settle();
    @(posedge clk);
    #1;
    rst = 1'b0; valid = 1'b0; commit = 1'b0; taken = 1'b0; misp = 1'b0;
    settle();
    checkOutput("midReset brA",   ifA.pr_perf_branches, 32'd0);
    checkOutput("midReset mpA",   ifA.pr_perf_mispredicts, 32'd0);
    checkOutput("midReset histA", 32'(ifA.pr_to_if_hist), 32'd0);
    checkOutput("midReset predA", 32'(ifA.pr_to_if_prediction), 32'd1);
    checkOutput("midReset predB", 32'(ifB.pr_to_if_prediction), 32'd1);

    // Counter walk at entry 0x40: A from 10, B from 100.
    commitBurst(1, 1'b0);
    checkOutput("walk1 predA", 32'(ifA.pr_to_if_prediction), 32'd0);
    checkOutput("walk1 predB", 32'(ifB.pr_to_if_prediction), 32'd0);
    commitBurst(5, 1'b1);
    checkOutput("walk2 predA", 32'(ifA.pr_to_if_prediction), 32'd1);
    checkOutput("walk2 predB", 32'(ifB.pr_to_if_prediction), 32'd1);
    commitBurst(3, 1'b0);
    checkOutput("satHigh predA", 32'(ifA.pr_to_if_prediction), 32'd0);
    checkOutput("satHigh predB", 32'(ifB.pr_to_if_prediction), 32'd1);
    commitBurst(5, 1'b0);
    checkOutput("walk4 predB", 32'(ifB.pr_to_if_prediction), 32'd0);
    commitBurst(3, 1'b1);
    checkOutput("satLow predA", 32'(ifA.pr_to_if_prediction), 32'd1);
    checkOutput("satLow predB", 32'(ifB.pr_to_if_prediction), 32'd0);
    commitBurst(1, 1'b1);
    checkOutput("walk6 predB", 32'(ifB.pr_to_if_prediction), 32'd1);
    checkOutput("walk brA",    ifA.pr_perf_branches, 32'd18);
    checkOutput("walk mpB",    ifB.pr_perf_mispredicts, 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk_in and rst_in as in the rest of the codebase.
REQ-002 Parameter SHALL be ADDR_W, default 32, meaning PC width.
REQ-003 Parameter SHALL be IDX_W, default 7, meaning PHT index width (2^IDX_W entries).
REQ-004 Parameter SHALL be CTR_W, default 2, meaning saturating counter width (legal range 1..4).
REQ-005 Parameter SHALL be HIST_W, default 6, meaning global history length (legal range 1..IDX_W).
REQ-006 Port SHALL be clk_in  input  1  clock.
REQ-007 Port SHALL be rst_in  input  1  async active-high reset.
REQ-008 Port SHALL be rdy_in  input  1  global enable; when low, all state SHALL be frozen.
REQ-009 Port SHALL be if_to_pr_PC  input  ADDR_W  fetch PC to predict.
REQ-010 Port SHALL be if_to_pr_valid  input  1  fetch issued a branch this cycle; speculatively advances history.
REQ-011 Port SHALL be pr_to_if_prediction  output  1  predicted taken.
REQ-012 Port SHALL be pr_to_if_hist  output  HIST_W  speculative history snapshot, carried with the branch to the ROB.
REQ-013 Port SHALL be rob_to_pr_br_commit  input  1  branch commits this cycle.
REQ-014 Port SHALL be rob_to_pr_PC  input  ADDR_W  committing branch PC.
REQ-015 Port SHALL be rob_to_pr_hist  input  HIST_W  history snapshot captured at that branch's prediction.
REQ-016 Port SHALL be rob_to_pr_br_taken  input  1  resolved direction.
REQ-017 Port SHALL be rob_to_pr_mispredict  input  1  committing branch was mispredicted; qualified by br_commit.
REQ-018 Port SHALL be pr_perf_branches  output  32  committed-branch count.
REQ-019 Port SHALL be pr_perf_mispredicts  output  32  mispredict count.

Function
REQ-020 Lookup index SHALL be if_to_pr_PC[IDX_W+1:2] XOR zero-extended spec_ghr; the prediction SHALL be the MSB of the indexed counter, combinational with zero latency.
REQ-021 Update index SHALL be rob_to_pr_PC[IDX_W+1:2] XOR zero-extended rob_to_pr_hist.
REQ-022 On br_commit, the indexed counter SHALL increment if taken and below 2^CTR_W-1, decrement if not taken and above 0, and otherwise hold (saturate, no wrap).
REQ-023 A same-cycle lookup and update to the same index SHALL return the pre-update value (no bypass); the new value SHALL be visible on the next cycle.
REQ-024 On if_to_pr_valid without mispredict, spec_ghr SHALL become {spec_ghr[HIST_W-2:0], prediction} at the next edge.
REQ-025 On br_commit, arch_ghr SHALL become {arch_ghr[HIST_W-2:0], br_taken}.
REQ-026 On br_commit with mispredict, spec_ghr SHALL become {arch_ghr[HIST_W-2:0], br_taken}, overriding any same-cycle if_to_pr_valid.
REQ-027 pr_perf_branches SHALL increment on every br_commit; pr_perf_mispredicts SHALL increment on br_commit with mispredict; both SHALL saturate at 2^32-1.
REQ-028 mispredict without br_commit SHALL be ignored.
REQ-029 pr_to_if_hist SHALL equal the current spec_ghr (the pre-shift value for the current lookup).

Reset
REQ-030 rst_in SHALL asynchronously set every counter to 2^(CTR_W-1) (weakly taken), set spec_ghr and arch_ghr to 0, and set both perf counters to 0.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight update of that cycle.
REQ-032 After reset, pr_to_if_prediction SHALL be 1 and pr_to_if_hist SHALL be 0.

Structure
REQ-033 The shared package SHALL hold ADDR_W default, PREDICTOR index/counter/history width defaults, and the counter reset constant.
REQ-034 One sub-module SHALL exist: sat_counter_update (combinational next-state for a CTR_W-bit saturating counter), instantiated once on the update path.
REQ-035 The PHT SHALL be a register array; no SRAM macro SHALL be used.

Verification
REQ-036 Reset, then look up any PC -> prediction 1, hist 0, perf counters 0.
REQ-037 Defaults: commit PC 0x100, hist 0, not-taken twice -> counter 00; lookup PC 0x100 with spec_ghr 0 -> prediction 0; a third not-taken commit leaves the counter at 00.
REQ-038 Three if_to_pr_valid with predictions 1,0,1 from reset -> spec_ghr 6'b000101; then commit taken with mispredict, arch_ghr 0 -> spec_ghr 6'b000001.
REQ-039 Same cycle: if_to_pr_valid and mispredict commit -> spec_ghr follows the REQ-026 restore value, not the shift.
REQ-040 Same-index commit taken and lookup from counter 01 -> same-cycle prediction 0, next-cycle prediction 1.
REQ-041 rdy_in low for 5 cycles with commit and valid active -> no counter, history or perf change; CTR_W=3, HIST_W=4 regression -> counter reset value 100, saturation at 111 and 000.
